ahb_bm_input_stage: RTL and testbench

- Per-master input stage of the AHB bus matrix; sits between one master (slave-side AHB port) and the decoder/output stages.
- Registers ("holds") an address phase that cannot be accepted immediately because the target output stage is busy or granted to another port.
- Presents a stable held_tran/address/control bundle to the output stages until it is granted.
- Stretches HREADYOUTS to the master while holding, and forwards data-phase ready/response.

---
 rtl/ahb_bm_input_stage_pkg.sv | 21 ++
 rtl/ahb_bm_input_stage_if.sv | 48 ++++
 rtl/ahb_bm_input_stage.sv | 60 ++++++
 tb/tb_ahb_bm_input_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bm_input_stage_pkg.sv
// ahb_bm_pkg: shared AHB bus-matrix constants and the address-phase control bundle
package ahb_bm_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int AUSER_W_DEF = 32;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HBURST_INCR4 = 3'b011;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic [3:0] master;
    logic       lock;
  } ctrl_t;
endpackage

// File: rtl/ahb_bm_input_stage_if.sv
// ahb_bm_input_stage_if: master-side AHB port plus matrix-side request/grant bundle of one input stage
//   slave modport : the input stage's view (master signals and grant/data-phase status in, request bundle out)
//   master modport: the surrounding master + matrix view
interface ahb_bm_input_stage_if #(
  parameter int ADDR_W = ahb_bm_pkg::ADDR_W_DEF,
  parameter int AUSER_W = ahb_bm_pkg::AUSER_W_DEF
);
  logic               HSELS;
  logic [ADDR_W-1:0]  HADDRS;
  logic [AUSER_W-1:0] HAUSERS;
  logic [1:0]         HTRANSS;
  logic               HWRITES;
  logic [2:0]         HSIZES;
  logic [2:0]         HBURSTS;
  logic [3:0]         HPROTS;
  logic [3:0]         HMASTERS;
  logic               HMASTLOCKS;
  logic               HREADYS;
  logic               HREADYOUTS;
  logic               HRESPS;
  logic               active_ip;
  logic               addr_ready_ip;
  logic               readyout_ip;
  logic               resp_ip;
  logic               sel_ip;
  logic [ADDR_W-1:0]  addr_ip;
  logic [AUSER_W-1:0] auser_ip;
  logic [1:0]         trans_ip;
  logic               write_ip;
  logic [2:0]         size_ip;
  logic [2:0]         burst_ip;
  logic [3:0]         prot_ip;
  logic [3:0]         master_ip;
  logic               mastlock_ip;
  logic               held_tran_ip;
  modport slave (
    input  HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
    input  active_ip, addr_ready_ip, readyout_ip, resp_ip,
    output HREADYOUTS, HRESPS, sel_ip, addr_ip, auser_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip,
    output master_ip, mastlock_ip, held_tran_ip
  );
  modport master (
    output HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
    output active_ip, addr_ready_ip, readyout_ip, resp_ip,
    input  HREADYOUTS, HRESPS, sel_ip, addr_ip, auser_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip,
    input  master_ip, mastlock_ip, held_tran_ip
  );
endinterface

// File: rtl/ahb_bm_input_stage.sv
// ahb_bm_input_stage: per-master bus-matrix input stage that holds a contended address phase until granted
//   HCLK/HRESETn: clock and asynchronous active-low reset
//   bus (slave) : master AHB signals in, HREADYOUTS/HRESPS back, live-or-held request bundle to output stages
module ahb_bm_input_stage
  import ahb_bm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int AUSER_W = AUSER_W_DEF
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_bm_input_stage_if.slave bus
);
  ctrl_t live_ctrl, out_ctrl, hold_ctrl_q, hold_ctrl_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [AUSER_W-1:0] hold_auser_q, hold_auser_d;
  logic pend_tran_q, pend_tran_d, data_phase_q, data_phase_d;
  logic trans_valid, accept, capture;
  always_comb begin
    live_ctrl = {bus.HTRANSS, bus.HWRITES, bus.HSIZES, bus.HBURSTS, bus.HPROTS, bus.HMASTERS, bus.HMASTLOCKS};
    trans_valid = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
    accept = bus.active_ip & bus.addr_ready_ip;
    capture = trans_valid & ~pend_tran_q & ~accept;
    pend_tran_d = capture | (pend_tran_q & ~accept);
    // a grant of a live or held request opens a data phase; otherwise it closes when the slave is ready
    data_phase_d = (pend_tran_q | trans_valid) & accept ? 1'b1 :
                   data_phase_q & bus.readyout_ip & ~accept ? 1'b0 : data_phase_q;
    hold_ctrl_d = capture ? live_ctrl : hold_ctrl_q;
    hold_addr_d = capture ? bus.HADDRS : hold_addr_q;
    hold_auser_d = capture ? bus.HAUSERS : hold_auser_q;
    out_ctrl = pend_tran_q ? hold_ctrl_q : live_ctrl;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      pend_tran_q <= 1'b0;
      data_phase_q <= 1'b0;
      hold_ctrl_q <= '0;
      hold_addr_q <= '0;
      hold_auser_q <= '0;
    end else begin
      pend_tran_q <= pend_tran_d;
      data_phase_q <= data_phase_d;
      hold_ctrl_q <= hold_ctrl_d;
      hold_addr_q <= hold_addr_d;
      hold_auser_q <= hold_auser_d;
    end
  assign bus.sel_ip = pend_tran_q | bus.HSELS;
  assign bus.addr_ip = pend_tran_q ? hold_addr_q : bus.HADDRS;
  assign bus.auser_ip = pend_tran_q ? hold_auser_q : bus.HAUSERS;
  assign bus.trans_ip = out_ctrl.trans;
  assign bus.write_ip = out_ctrl.write;
  assign bus.size_ip = out_ctrl.size;
  assign bus.burst_ip = out_ctrl.burst;
  assign bus.prot_ip = out_ctrl.prot;
  assign bus.master_ip = out_ctrl.master;
  assign bus.mastlock_ip = out_ctrl.lock;
  assign bus.held_tran_ip = pend_tran_q | trans_valid;
  assign bus.HREADYOUTS = ~pend_tran_q & (~data_phase_q | bus.readyout_ip);
  assign bus.HRESPS = data_phase_q ? bus.resp_ip : HRESP_OKAY;
endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// tb_ahb_bm_input_stage: directed and randomized checks of the input stage against a queue-based model
module tb_ahb_bm_input_stage;
  import ahb_bm_pkg::*;
  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [31:0] auser;
    ctrl_t       c;
  } bnd_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  bnd_t held_q[$];
  bit m_dp = 1'b0;
  ahb_bm_input_stage_if bus ();
  assign bus.HREADYS = bus.HREADYOUTS;
  ahb_bm_input_stage dut (.HCLK(clk), .HRESETn(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic bnd_t live_b();
    bnd_t b;
    b.sel = bus.HSELS;
    b.addr = bus.HADDRS;
    b.auser = bus.HAUSERS;
    b.c.trans = bus.HTRANSS;
    b.c.write = bus.HWRITES;
    b.c.size = bus.HSIZES;
    b.c.burst = bus.HBURSTS;
    b.c.prot = bus.HPROTS;
    b.c.master = bus.HMASTERS;
    b.c.lock = bus.HMASTLOCKS;
    return b;
  endfunction
  function automatic logic exp_rdy();
    return held_q.size() != 0 ? 1'b0 : m_dp ? bus.readyout_ip : 1'b1;
  endfunction
  function automatic logic req_live();
    return bus.HSELS & bus.HTRANSS[1] & exp_rdy();
  endfunction
  task automatic compare();
    bnd_t e;
    e = held_q.size() != 0 ? held_q[0] : live_b();
    chk("sel_ip", 64'(bus.sel_ip), 64'(e.sel));
    chk("addr_ip", 64'(bus.addr_ip), 64'(e.addr));
    chk("auser_ip", 64'(bus.auser_ip), 64'(e.auser));
    chk("trans_ip", 64'(bus.trans_ip), 64'(e.c.trans));
    chk("write_ip", 64'(bus.write_ip), 64'(e.c.write));
    chk("size_ip", 64'(bus.size_ip), 64'(e.c.size));
    chk("burst_ip", 64'(bus.burst_ip), 64'(e.c.burst));
    chk("prot_ip", 64'(bus.prot_ip), 64'(e.c.prot));
    chk("master_ip", 64'(bus.master_ip), 64'(e.c.master));
    chk("mastlock_ip", 64'(bus.mastlock_ip), 64'(e.c.lock));
    chk("held_tran_ip", 64'(bus.held_tran_ip), 64'(held_q.size() != 0 || req_live()));
    chk("HREADYOUTS", 64'(bus.HREADYOUTS), 64'(exp_rdy()));
    chk("HRESPS", 64'(bus.HRESPS), 64'(m_dp ? bus.resp_ip : HRESP_OKAY));
  endtask
  task automatic advance();
    bnd_t b;
    logic acc, tv;
    if (!rst_n) begin
      held_q.delete();
      m_dp = 1'b0;
      return;
    end
    acc = bus.active_ip & bus.addr_ready_ip;
    tv = req_live();
    if (m_dp && bus.readyout_ip && !acc) m_dp = 1'b0;
    if (held_q.size() != 0) begin
      if (acc) begin
        void'(held_q.pop_front());
        m_dp = 1'b1;
      end
    end else if (tv) begin
      if (acc) m_dp = 1'b1;
      else begin
        b = live_b();
        b.sel = 1'b1;
        held_q.push_back(b);
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    compare();
    advance();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.HSELS = 1'b0;
    bus.HTRANSS = HTRANS_IDLE;
    bus.HADDRS = '0;
    bus.HAUSERS = '0;
    bus.HWRITES = 1'b0;
    bus.HSIZES = '0;
    bus.HBURSTS = '0;
    bus.HPROTS = '0;
    bus.HMASTERS = '0;
    bus.HMASTLOCKS = 1'b0;
    bus.active_ip = 1'b0;
    bus.addr_ready_ip = 1'b1;
    bus.readyout_ip = 1'b1;
    bus.resp_ip = HRESP_OKAY;
  endtask
  task automatic req(input logic [1:0] t, input logic [31:0] a, input logic act);
    bus.HSELS = 1'b1;
    bus.HTRANSS = t;
    bus.HADDRS = a;
    bus.HWRITES = 1'b1;
    bus.HSIZES = 3'd2;
    bus.active_ip = act;
  endtask
  initial begin
    idle();
    #1;
    chk("reset HREADYOUTS", 64'(bus.HREADYOUTS), 64'd1);
    chk("reset HRESPS", 64'(bus.HRESPS), 64'd0);
    chk("reset held_tran_ip", 64'(bus.held_tran_ip), 64'd0);
    chk("reset trans_ip", 64'(bus.trans_ip), 64'(HTRANS_IDLE));
    step();
    step();
    rst_n = 1'b1;
    step();
    req(HTRANS_NONSEQ, 32'h0000_1000, 1'b1);
    #1;
    chk("uncont held_tran_ip", 64'(bus.held_tran_ip), 64'd1);
    chk("uncont addr_ip", 64'(bus.addr_ip), 64'h0000_1000);
    step();
    idle();
    bus.readyout_ip = 1'b0;
    #1;
    chk("uncont dp HREADYOUTS low", 64'(bus.HREADYOUTS), 64'd0);
    step();
    bus.readyout_ip = 1'b1;
    #1;
    chk("uncont dp HREADYOUTS high", 64'(bus.HREADYOUTS), 64'd1);
    step();
    req(HTRANS_NONSEQ, 32'h2000_0040, 1'b0);
    bus.HMASTLOCKS = 1'b1;
    #1;
    chk("cont first HREADYOUTS", 64'(bus.HREADYOUTS), 64'd1);
    step();
    for (int k = 0; k < 3; k++) begin
      bus.HADDRS = $urandom;
      bus.HMASTLOCKS = 1'b0;
      bus.active_ip = (k == 2);
      #1;
      chk("cont held addr_ip", 64'(bus.addr_ip), 64'h2000_0040);
      chk("cont HREADYOUTS", 64'(bus.HREADYOUTS), 64'd0);
      chk("cont mastlock_ip", 64'(bus.mastlock_ip), 64'd1);
      step();
    end
    idle();
    #1;
    chk("cont released HREADYOUTS", 64'(bus.HREADYOUTS), 64'd1);
    step();
    req(HTRANS_SEQ, 32'h3000_0004, 1'b0);
    bus.HBURSTS = HBURST_INCR4;
    step();
    bus.HTRANSS = HTRANS_BUSY;
    bus.HBURSTS = 3'b000;
    bus.active_ip = 1'b1;
    #1;
    chk("burst held trans_ip", 64'(bus.trans_ip), 64'(HTRANS_SEQ));
    chk("burst held burst_ip", 64'(bus.burst_ip), 64'(HBURST_INCR4));
    step();
    req(HTRANS_SEQ, 32'h3000_0008, 1'b1);
    bus.HBURSTS = HBURST_INCR4;
    #1;
    chk("burst live addr_ip", 64'(bus.addr_ip), 64'h3000_0008);
    chk("burst live HREADYOUTS", 64'(bus.HREADYOUTS), 64'd1);
    step();
    idle();
    bus.readyout_ip = 1'b0;
    bus.resp_ip = HRESP_ERROR;
    #1;
    chk("err c1 HRESPS", 64'(bus.HRESPS), 64'd1);
    chk("err c1 HREADYOUTS", 64'(bus.HREADYOUTS), 64'd0);
    step();
    bus.readyout_ip = 1'b1;
    bus.HSELS = 1'b1;
    #1;
    chk("err c2 HRESPS", 64'(bus.HRESPS), 64'd1);
    chk("err c2 HREADYOUTS", 64'(bus.HREADYOUTS), 64'd1);
    chk("err idle not held", 64'(bus.held_tran_ip), 64'd0);
    step();
    idle();
    #1;
    chk("err after HRESPS", 64'(bus.HRESPS), 64'd0);
    step();
    req(HTRANS_BUSY, 32'h5000_0000, 1'b0);
    #1;
    chk("busy held_tran_ip", 64'(bus.held_tran_ip), 64'd0);
    step();
    chk("busy no capture HREADYOUTS", 64'(bus.HREADYOUTS), 64'd1);
    step();
    req(HTRANS_NONSEQ, 32'h4000_0000, 1'b0);
    step();
    chk("rst pre held_tran_ip", 64'(bus.held_tran_ip), 64'd1);
    rst_n = 1'b0;
    bus.HTRANSS = HTRANS_IDLE;
    held_q.delete();
    m_dp = 1'b0;
    #1;
    chk("rst async held_tran_ip", 64'(bus.held_tran_ip), 64'd0);
    chk("rst async HREADYOUTS", 64'(bus.HREADYOUTS), 64'd1);
    chk("rst async trans_ip", 64'(bus.trans_ip), 64'(HTRANS_IDLE));
    step();
    rst_n = 1'b1;
    idle();
    step();
    for (int i = 0; i < 3000; i++) begin
      bus.HSELS = ($urandom_range(0, 3) != 0);
      bus.HTRANSS = 2'($urandom);
      bus.HADDRS = $urandom;
      bus.HAUSERS = $urandom;
      bus.HWRITES = 1'($urandom);
      bus.HSIZES = 3'($urandom_range(0, 2));
      bus.HBURSTS = 3'($urandom);
      bus.HPROTS = 4'($urandom);
      bus.HMASTERS = 4'($urandom);
      bus.HMASTLOCKS = 1'($urandom);
      bus.readyout_ip = ($urandom_range(0, 3) != 0);
      bus.resp_ip = 1'($urandom);
      bus.addr_ready_ip = ($urandom_range(0, 2) != 0);
      bus.active_ip = 1'($urandom) & (held_q.size() != 0 || req_live());
      if (i == 1500) begin
        rst_n = 1'b0;
        held_q.delete();
        m_dp = 1'b0;
      end
      if (i == 1502) rst_n = 1'b1;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
